// File: rtl/draw_sequencer.sv
// draw_sequencer: initiator side of the per-object draw/draw_done handshake.
// Drives the draw enable of the map, link and enemies sources in that fixed
// order each frame, waits for each done (or a timeout), and muxes the active
// source's pixel stream into one registered VGA write port.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   start               frame request, honoured only when idle
//   draw_<src>          draw enables, decoded from the state register
//   <src>_done          level done from each source
//   <src>_x/_y/_colour/_write  source pixel streams
//   x_out, y_out, colour_out, VGA_write  registered pixel to the VGA adapter
//   frame_done          one-cycle pulse at frame end
//   busy                high whenever the sequencer is not idle
//   timeout_err         sticky abort flags {enemies, link, map}
module draw_sequencer #(
  parameter int unsigned     TO_W    = 17,
  parameter logic [TO_W-1:0] TIMEOUT = 17'd100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       draw_map,
  output logic       draw_link,
  output logic       draw_enemies,
  input  logic       map_done,
  input  logic       link_done,
  input  logic       enemies_done,
  input  logic [8:0] map_x,
  input  logic [8:0] link_x,
  input  logic [8:0] enemies_x,
  input  logic [7:0] map_y,
  input  logic [7:0] link_y,
  input  logic [7:0] enemies_y,
  input  logic [5:0] map_colour,
  input  logic [5:0] link_colour,
  input  logic [5:0] enemies_colour,
  input  logic       map_write,
  input  logic       link_write,
  input  logic       enemies_write,
  output logic [8:0] x_out,
  output logic [7:0] y_out,
  output logic [5:0] colour_out,
  output logic       VGA_write,
  output logic       frame_done,
  output logic       busy,
  output logic [2:0] timeout_err
);

  localparam logic [TO_W-1:0] TO_LAST = TIMEOUT - TO_W'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_MAP, S_MAP_REL, S_LINK, S_LINK_REL, S_ENEM, S_ENEM_REL, S_DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  logic            active;
  logic [2:0]      err_set;
  logic [8:0]      mux_x;
  logic [7:0]      mux_y;
  logic [5:0]      mux_colour;
  logic            mux_write;

  // Draw enables are a pure decode of the state register, so they drop the
  // cycle a done is accepted and stay low for the whole release cycle.
  assign draw_map     = (state == S_MAP);
  assign draw_link    = (state == S_LINK);
  assign draw_enemies = (state == S_ENEM);

  assign active = draw_map || draw_link || draw_enemies;
  assign to_hit = (to_cnt == TO_LAST);

  // Next state and timeout flags; a done on the timeout cycle takes priority.
  always_comb begin
    state_nxt = state;
    err_set   = 3'b000;
    case (state)
      S_IDLE:     if (start) state_nxt = S_MAP;
      S_MAP: begin
        if (map_done || to_hit) state_nxt = S_MAP_REL;
        err_set[0] = to_hit && !map_done;
      end
      S_MAP_REL:  state_nxt = S_LINK;
      S_LINK: begin
        if (link_done || to_hit) state_nxt = S_LINK_REL;
        err_set[1] = to_hit && !link_done;
      end
      S_LINK_REL: state_nxt = S_ENEM;
      S_ENEM: begin
        if (enemies_done || to_hit) state_nxt = S_ENEM_REL;
        err_set[2] = to_hit && !enemies_done;
      end
      S_ENEM_REL: state_nxt = S_DONE;
      S_DONE:     state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Pixel mux: only the source in its active state reaches the VGA port.
  always_comb begin
    mux_x      = 9'd0;
    mux_y      = 8'd0;
    mux_colour = 6'd0;
    mux_write  = 1'b0;
    case (state)
      S_MAP: begin
        mux_x = map_x; mux_y = map_y; mux_colour = map_colour; mux_write = map_write;
      end
      S_LINK: begin
        mux_x = link_x; mux_y = link_y; mux_colour = link_colour; mux_write = link_write;
      end
      S_ENEM: begin
        mux_x = enemies_x; mux_y = enemies_y; mux_colour = enemies_colour;
        mux_write = enemies_write;
      end
      default: ;
    endcase
  end

  // State register, timeout counter and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      to_cnt      <= '0;
      x_out       <= 9'd0;
      y_out       <= 8'd0;
      colour_out  <= 6'd0;
      VGA_write   <= 1'b0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 3'b000;
    end else begin
      state       <= state_nxt;
      to_cnt      <= (active && (state_nxt == state)) ? to_cnt + TO_W'(1) : '0;
      x_out       <= mux_x;
      y_out       <= mux_y;
      colour_out  <= mux_colour;
      VGA_write   <= mux_write;
      frame_done  <= (state_nxt == S_DONE);
      busy        <= (state_nxt != S_IDLE);
      if (state == S_IDLE && start)
        timeout_err <= 3'b000;
      else
        timeout_err <= timeout_err | err_set;
    end
  end

endmodule

// File: tb/tb_draw_sequencer.sv
// Bench for draw_sequencer: a cycle table for the nominal frame, then
// hand-written sequences for timeout, coincident done, error clearing and
// mid-frame reset using a small behavioural source model.
module tb_draw_sequencer;

  localparam logic [16:0] TO = 17'd16;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       draw_map, draw_link, draw_enemies;
  logic       map_done, link_done, enemies_done;
  logic [8:0] map_x, link_x, enemies_x;
  logic [7:0] map_y, link_y, enemies_y;
  logic [5:0] map_colour, link_colour, enemies_colour;
  logic       map_write, link_write, enemies_write;
  logic [8:0] x_out;
  logic [7:0] y_out;
  logic [5:0] colour_out;
  logic       VGA_write, frame_done, busy;
  logic [2:0] timeout_err;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  draw_sequencer #(.TO_W(17), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .start(start),
    .draw_map(draw_map), .draw_link(draw_link), .draw_enemies(draw_enemies),
    .map_done(map_done), .link_done(link_done), .enemies_done(enemies_done),
    .map_x(map_x), .link_x(link_x), .enemies_x(enemies_x),
    .map_y(map_y), .link_y(link_y), .enemies_y(enemies_y),
    .map_colour(map_colour), .link_colour(link_colour), .enemies_colour(enemies_colour),
    .map_write(map_write), .link_write(link_write), .enemies_write(enemies_write),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out), .VGA_write(VGA_write),
    .frame_done(frame_done), .busy(busy), .timeout_err(timeout_err)
  );

  // Fixed per-source pixel data so the mux selection is visible on x/y/colour.
  assign map_x = 9'h101;      assign map_y = 8'h11;      assign map_colour = 6'h21;
  assign link_x = 9'h0a2;     assign link_y = 8'h22;     assign link_colour = 6'h12;
  assign enemies_x = 9'h1c3;  assign enemies_y = 8'h33;  assign enemies_colour = 6'h3f;

  // Source model: in auto mode a source writes every cycle its draw is high
  // and raises done once it has been drawn for dly cycles.
  logic auto_mode;
  logic tv_md, tv_ld, tv_ed, tv_mw, tv_lw, tv_ew;
  int   map_dly = 0, link_dly = 0, enem_dly = 0;
  int   map_cnt = 0, link_cnt = 0, enem_cnt = 0;

  always @(posedge clock) begin
    map_cnt  <= draw_map     ? map_cnt + 1  : 0;
    link_cnt <= draw_link    ? link_cnt + 1 : 0;
    enem_cnt <= draw_enemies ? enem_cnt + 1 : 0;
  end

  assign map_done      = auto_mode ? (draw_map && map_cnt >= map_dly) : tv_md;
  assign link_done     = auto_mode ? (draw_link && link_cnt >= link_dly) : tv_ld;
  assign enemies_done  = auto_mode ? (draw_enemies && enem_cnt >= enem_dly) : tv_ed;
  assign map_write     = auto_mode ? draw_map : tv_mw;
  assign link_write    = auto_mode ? draw_link : tv_lw;
  assign enemies_write = auto_mode ? draw_enemies : tv_ew;

  // in  = {start, map_done, link_done, enemies_done, map_w, link_w, enemies_w}
  // exp = {draw_map, draw_link, draw_enemies, VGA_write, frame_done, busy}
  // src = source whose state was active during the cycle (0 none, 1 map, 2 link, 3 enemies)
  typedef struct {
    logic [6:0] in;
    logic [5:0] exp;
    logic [1:0] src;
    logic [2:0] terr;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  function automatic logic [22:0] pix_of(input logic [1:0] src);
    case (src)
      2'd1:    return {9'h101, 8'h11, 6'h21};
      2'd2:    return {9'h0a2, 8'h22, 6'h12};
      2'd3:    return {9'h1c3, 8'h33, 6'h3f};
      default: return 23'd0;
    endcase
  endfunction

  // Start pulse, then count enable/write cycles until frame_done or budget.
  task automatic run_frame(output int nm, output int nl, output int ne, output int nw,
                           output int nf, output logic [2:0] first_draw,
                           output logic [2:0] first_terr);
    nm = 0; nl = 0; ne = 0; nw = 0; nf = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    first_draw = {draw_enemies, draw_link, draw_map};
    first_terr = timeout_err;
    for (int i = 0; i < 400; i++) begin
      nm += int'(draw_map);
      nl += int'(draw_link);
      ne += int'(draw_enemies);
      nw += int'(VGA_write);
      if (frame_done) begin
        nf = 1;
        break;
      end
      tick();
    end
  endtask

  int         nm, nl, ne, nw, nf;
  logic [2:0] fdraw, fterr;
  logic [5:0] got;

  initial begin
    vecs[0]  = '{7'b1000000, 6'b100001, 2'd0, 3'b000};
    vecs[1]  = '{7'b0000100, 6'b100101, 2'd1, 3'b000};
    vecs[2]  = '{7'b0000100, 6'b100101, 2'd1, 3'b000};
    vecs[3]  = '{7'b0000100, 6'b100101, 2'd1, 3'b000};
    vecs[4]  = '{7'b0100100, 6'b000101, 2'd1, 3'b000};
    vecs[5]  = '{7'b0100000, 6'b010001, 2'd0, 3'b000};
    vecs[6]  = '{7'b0100010, 6'b010101, 2'd2, 3'b000};
    vecs[7]  = '{7'b0000010, 6'b010101, 2'd2, 3'b000};
    vecs[8]  = '{7'b0010000, 6'b000001, 2'd2, 3'b000};
    vecs[9]  = '{7'b0000000, 6'b001001, 2'd0, 3'b000};
    vecs[10] = '{7'b1000001, 6'b001101, 2'd3, 3'b000};
    vecs[11] = '{7'b0000001, 6'b001101, 2'd3, 3'b000};
    vecs[12] = '{7'b0001001, 6'b000101, 2'd3, 3'b000};
    vecs[13] = '{7'b0000000, 6'b000011, 2'd0, 3'b000};
    vecs[14] = '{7'b0000000, 6'b000000, 2'd0, 3'b000};
    vecs[15] = '{7'b0000000, 6'b000000, 2'd0, 3'b000};

    auto_mode = 1'b0;
    {start, tv_md, tv_ld, tv_ed, tv_mw, tv_lw, tv_ew} = 7'b0;
    reset = 1'b1;
    tick();
    tick();
    got = {draw_map, draw_link, draw_enemies, VGA_write, frame_done, busy};
    chk("reset_ctrl", 32'(got), 32'd0);
    chk("reset_pix", 32'({x_out, y_out, colour_out}), 32'd0);
    chk("reset_terr", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    tick();

    // Nominal frame: map 4 writes, link 2, enemies 3, stale done and busy start.
    for (int i = 0; i < 16; i++) begin
      {start, tv_md, tv_ld, tv_ed, tv_mw, tv_lw, tv_ew} = vecs[i].in;
      tick();
      got = {draw_map, draw_link, draw_enemies, VGA_write, frame_done, busy};
      chk($sformatf("vec%0d_ctrl", i), 32'(got), 32'(vecs[i].exp));
      chk($sformatf("vec%0d_pix", i), 32'({x_out, y_out, colour_out}),
          32'(pix_of(vecs[i].src)));
      chk($sformatf("vec%0d_terr", i), 32'(timeout_err), 32'(vecs[i].terr));
    end

    // Map done coincides with the timeout cycle; link never finishes.
    auto_mode = 1'b1;
    map_dly = 15; link_dly = 1000; enem_dly = 2;
    run_frame(nm, nl, ne, nw, nf, fdraw, fterr);
    chk("to_first_draw", 32'(fdraw), 32'b001);
    chk("to_map_cycles", 32'(nm), 32'd16);
    chk("to_link_cycles", 32'(nl), 32'd16);
    chk("to_enem_cycles", 32'(ne), 32'd3);
    chk("to_writes", 32'(nw), 32'd35);
    chk("to_frame_done", 32'(nf), 32'd1);
    chk("to_terr", 32'(timeout_err), 32'b010);
    tick();
    chk("to_after_fd", 32'({frame_done, busy}), 32'd0);
    chk("to_terr_sticky", 32'(timeout_err), 32'b010);

    // A new start clears the previous error.
    map_dly = 1; link_dly = 1; enem_dly = 1;
    run_frame(nm, nl, ne, nw, nf, fdraw, fterr);
    chk("clr_terr_first", 32'(fterr), 32'b000);
    chk("clr_counts", 32'({nm[7:0], nl[7:0], ne[7:0]}), 32'h020202);
    chk("clr_writes", 32'(nw), 32'd6);
    chk("clr_frame_done", 32'(nf), 32'd1);
    chk("clr_terr_end", 32'(timeout_err), 32'b000);
    tick();

    // Reset in the middle of the link phase.
    map_dly = 1; link_dly = 1000; enem_dly = 1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !draw_link; i++) tick();
    tick();
    tick();
    chk("rst_pre_link", 32'({draw_link, VGA_write, busy}), 32'b111);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = {draw_map, draw_link, draw_enemies, VGA_write, frame_done, busy};
    chk("rst_mid_ctrl", 32'(got), 32'd0);
    tick();
    chk("rst_stays_idle", 32'({draw_map, busy}), 32'd0);
    map_dly = 2; link_dly = 1; enem_dly = 0;
    run_frame(nm, nl, ne, nw, nf, fdraw, fterr);
    chk("rst_first_draw", 32'(fdraw), 32'b001);
    chk("rst_counts", 32'({nm[7:0], nl[7:0], ne[7:0]}), 32'h030201);
    chk("rst_writes", 32'(nw), 32'd6);
    chk("rst_frame_done", 32'(nf), 32'd1);
    chk("rst_terr", 32'(timeout_err), 32'b000);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_sequencer.md
Name: draw_sequencer

Overview:
- Initiator side of the per-object draw/draw_done handshake.
- On each frame request it drives the draw enable of three pixel sources in fixed order: map background, link, then the enemies group.
- It waits for each source's draw_done and muxes that source's pixel stream (x, y, colour, write) into a single registered write port to the VGA adapter.
- It sits between the game control FSM and vga_adapter, and replaces ad-hoc muxing in the top level.

Parameters:
- TIMEOUT, 17'd100000: maximum cycles to wait for a source's draw_done before aborting that source.
- TO_W, 17: counter width for TIMEOUT.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  frame draw request; sampled only in S_IDLE
- draw_map  output  1  draw enable to map source
- draw_link  output  1  draw enable to link source
- draw_enemies  output  1  draw enable to enemies group
- map_done  input  1  level; high while source finished and its draw is high
- link_done  input  1  same, link
- enemies_done  input  1  same, enemies group
- map_x / link_x / enemies_x  input  9 each  source pixel x
- map_y / link_y / enemies_y  input  8 each  source pixel y
- map_colour / link_colour / enemies_colour  input  6 each  source pixel colour
- map_write / link_write / enemies_write  input  1 each  source pixel valid
- x_out  output  9  registered pixel x to VGA
- y_out  output  8  registered pixel y to VGA
- colour_out  output  6  registered pixel colour to VGA
- VGA_write  output  1  registered plot strobe
- frame_done  output  1  one-cycle pulse at frame end
- busy  output  1  high in any state except S_IDLE
- timeout_err  output  3  sticky per-source abort flags {enemies, link, map}; cleared on next accepted start

Behaviour:
- Reset: state=S_IDLE, all draw_* =0, x_out=0, y_out=0, colour_out=0, VGA_write=0, frame_done=0, busy=0, timeout_err=3'b0, timeout counter=0. Reset mid-frame aborts immediately; all draw enables drop the same cycle.
- States: S_IDLE, S_MAP, S_MAP_REL, S_LINK, S_LINK_REL, S_ENEM, S_ENEM_REL, S_DONE.
- S_IDLE + start=1 -> S_MAP; timeout_err cleared that cycle.
- S_MAP, S_LINK, S_ENEM (active states):
  - The matching draw_* output is 1, driven combinationally from state.
  - Counter increments each cycle.
  - Exit to the corresponding _REL state when done=1, or when counter==TIMEOUT-1 (timeout exit also sets the source's timeout_err bit).
  - If done and timeout coincide, done wins: no error bit is set.
- _REL states: all draw_*=0 for exactly one cycle so the source clears its done; counter reset to 0.
- Transitions: S_MAP_REL->S_LINK, S_LINK_REL->S_ENEM, S_ENEM_REL->S_DONE.
- S_DONE: frame_done=1 for one cycle, then -> S_IDLE. start is ignored outside S_IDLE; there is no queuing.
- Pixel mux:
  - Select the active source's x/y/colour/write in its active state only.
  - In all other states the mux output is zero and write=0.
  - Mux output is registered into x_out/y_out/colour_out/VGA_write, so the latency from source pixel to VGA port is 1 cycle.
  - The source's write on the same cycle as its done is still forwarded.
- Pixels in flight: the registered pixel from the last active cycle appears during the _REL cycle. No pixel is ever lost or duplicated at a handoff.
- busy: registered, equals (next state != S_IDLE).

Test Plan:
- Nominal frame:
  - Stimulus: start pulse; map asserts done after 4 writes, link after 2, enemies after 3.
  - Required: exactly 9 VGA_write pulses in source order, each 1 cycle after the source write; one _REL gap cycle between sources; frame_done pulse; timeout_err=000.
- Release handshake: draw_map must be 0 on the cycle after map_done is first seen. A source whose done stays high while draw is low must not skip S_LINK.
- Timeout: TIMEOUT=16, link never asserts done -> draw_link high exactly 16 cycles; timeout_err=3'b010; enemies is still drawn; frame_done pulses.
- Coincident done and timeout: map_done rises on cycle TIMEOUT-1 -> timeout_err[0]=0.
- Reset mid-frame: assert reset during S_LINK -> next cycle all draw_*=0, VGA_write=0, busy=0. A following start runs a full frame from S_MAP.
- start ignored while busy; a second start in S_ENEM produces no extra frame. A new start after frame_done clears a prior timeout_err.
